td4_run_ctrl: RTL and testbench
===============================

TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 Interface SHALL use one clock; reset SHALL be synchronous and active-high: clk in 1, rising-edge clock for all state.
REQ-002 rst  in  1  synchronous active-high reset.
REQ-003 run_req  in  1  start free-running execution (level sampled at clk).
REQ-004 halt_req  in  1  stop execution / abort load.
REQ-005 step_req  in  1  execute exactly one instruction.
REQ-006 load_req  in  1  enter program-load mode.
REQ-007 pc  in  4  current CPU program counter.
REQ-008 bp_addr  in  4  breakpoint address; bp_en  in  1  breakpoint enable.
REQ-009 ld_valid  in  1, ld_data  in  8: program byte offered; ld_ready  out  1: byte accepted when valid & ready.
REQ-010 cpu_en  out  1  load enable gating all CPU register/PC updates.
REQ-011 mem_we  out  1, mem_waddr  out  4, mem_wdata  out  8: program memory write port.
REQ-012 state  out  2  IDLE=00, RUN=01, STEP=10, LOAD=11; halted  out  1 = (state==IDLE).
REQ-013 load_done  out  1 (one-cycle pulse); bp_hit  out  1 (one-cycle pulse); cycle_cnt  out  8 executed-cycle count.

Function
REQ-014 Request priority when several asserted in same cycle SHALL be halt > load > step > run.
REQ-015 IDLE: load_req->LOAD; step_req->STEP; run_req->RUN; else stay.
REQ-016 RUN: halt_req->IDLE; load_req->LOAD; breakpoint hit->IDLE; step_req/run_req ignored.
REQ-017 STEP SHALL last exactly one cycle with cpu_en=1, then IDLE; halt_req in STEP cycle forces cpu_en=0 and IDLE.
REQ-018 cpu_en SHALL be combinational: 1 in STEP (no halt_req), 1 in RUN unless halt_req, load_req or breakpoint hit that cycle; 0 in IDLE and LOAD.
REQ-019 Breakpoint hit = state RUN & bp_en & pc==bp_addr & not first RUN cycle; hit cycle has cpu_en=0, pulses bp_hit, next state IDLE.
REQ-020 First cycle after entering RUN SHALL ignore breakpoint so resume from a breakpointed pc executes that instruction.
REQ-021 LOAD: ld_ready=1; each valid&ready cycle drives mem_we=1, mem_waddr=load pointer, mem_wdata=ld_data combinationally; pointer increments.
REQ-022 Load pointer SHALL reset to 0 on entering LOAD; after write at address 15 state->IDLE and load_done pulses next cycle; pointer wraps to 0.
REQ-023 halt_req in LOAD SHALL abort: no write that cycle (ld_ready=0), IDLE next cycle, no load_done; already-written bytes keep.
REQ-024 mem_we SHALL be 0 outside LOAD.
REQ-025 cycle_cnt SHALL increment on every cycle with cpu_en=1, saturate at 255, clear to 0 on entering LOAD.

Reset
REQ-026 rst SHALL take priority over all inputs; next state IDLE.
REQ-027 Reset values: state=00, halted=1, cpu_en=0, ld_ready=0, mem_we=0, mem_waddr=0, load_done=0, bp_hit=0, cycle_cnt=0, load pointer=0, first-RUN flag clear.
REQ-028 rst during LOAD SHALL abandon load without load_done; during RUN SHALL deassert cpu_en in same cycle.

Configuration
REQ-029 Macro TD4_BREAKPOINT_EN defined: REQ-019/020 active.
REQ-030 Macro undefined: bp_addr/bp_en ports present but ignored, bp_hit tied 0, RUN exits only via halt_req/load_req/rst.

Verification
REQ-031 rst, load_req, 16 bytes 0x00..0x0F with ld_valid held -> mem_we 16 cycles, addresses 0..15, load_done one pulse, state IDLE.
REQ-032 load 5 bytes with ld_valid gaps, then halt_req -> 5 writes only, no load_done, IDLE; next load restarts at address 0.
REQ-033 IDLE, step_req 1 cycle -> cpu_en=1 exactly one cycle, cycle_cnt=1, state IDLE.
REQ-034 bp_en=1, bp_addr=3, run_req, pc 0,1,2,3 -> cpu_en 0 and bp_hit pulse when pc=3, IDLE; run_req again -> cpu_en=1 first cycle with pc=3.
REQ-035 run_req and halt_req same cycle -> stays IDLE, cpu_en=0; RUN for 300 cycles -> cycle_cnt=255.
REQ-036 rst asserted mid-RUN and mid-LOAD -> all outputs at REQ-027 values next cycle, cpu_en=0 in rst cycle.

Source files
------------

// File: rtl/td4_run_ctrl_if.sv
// Program-load stream and program-memory write port of the TD4 run controller.
// Signals: ld_valid/ld_data/ld_ready byte stream in; mem_we/mem_waddr/mem_wdata write port out.
// master = host/bench side (drives the load stream), slave = controller side.
interface td4_run_ctrl_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;

  modport master (
    output ld_valid, ld_data,
    input  ld_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  ld_valid, ld_data,
    output ld_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/td4_run_ctrl.sv
// TD4 run controller: IDLE/RUN/STEP/LOAD sequencing, CPU enable gating, program loader.
// Latency: cpu_en/bp_hit/ld_ready/mem_* combinational; state, load_done, cycle_cnt registered.
// Backpressure: ld_ready high only in LOAD without halt/rst; a byte is written when ld_valid & ld_ready.
// Ports: clk, rst (sync, active-high); i_run_req/i_halt_req/i_step_req/i_load_req requests;
//   i_pc, i_bp_addr, i_bp_en breakpoint inputs; io_bus load stream + memory write port;
//   o_cpu_en, o_state, o_halted, o_load_done, o_bp_hit, o_cycle_cnt.
// Optional feature: define TD4_BREAKPOINT_EN to enable breakpoints; otherwise bp inputs are ignored.
module td4_run_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_run_req,
  input  logic                 i_halt_req,
  input  logic                 i_step_req,
  input  logic                 i_load_req,
  input  logic [3:0]           i_pc,
  input  logic [3:0]           i_bp_addr,
  input  logic                 i_bp_en,
  td4_run_ctrl_if.slave        io_bus,
  output logic                 o_cpu_en,
  output logic [1:0]           o_state,
  output logic                 o_halted,
  output logic                 o_load_done,
  output logic                 o_bp_hit,
  output logic [7:0]           o_cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_LOAD = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_ptr;
  logic       r_load_done;
  logic [7:0] r_cycle_cnt;
  logic       w_bp_hit;
  logic       w_cpu_en;
  logic       w_ld_ready;
  logic       w_wr;
  logic       w_enter_load;

`ifdef TD4_BREAKPOINT_EN
  // Set for the first RUN cycle only, so resuming at a breakpointed pc
  // executes that instruction instead of re-hitting immediately.
  logic r_first_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_first_run <= 1'b0;
    end else begin
      r_first_run <= (w_next == S_RUN) && (r_state != S_RUN);
    end
  end

  assign w_bp_hit = !rst && (r_state == S_RUN) && i_bp_en &&
                    (i_pc == i_bp_addr) && !r_first_run;
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{i_bp_en, i_bp_addr, i_pc};
  assign w_bp_hit    = 1'b0;
`endif

  // Next state and combinational outputs; request priority halt > load > step > run.
  always_comb begin
    w_next     = r_state;
    w_cpu_en   = 1'b0;
    w_ld_ready = 1'b0;
    w_wr       = 1'b0;
    if (rst) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_halt_req)      w_next = S_IDLE;
          else if (i_load_req) w_next = S_LOAD;
          else if (i_step_req) w_next = S_STEP;
          else if (i_run_req)  w_next = S_RUN;
        end
        S_RUN: begin
          if (i_halt_req)      w_next = S_IDLE;
          else if (i_load_req) w_next = S_LOAD;
          else if (w_bp_hit)   w_next = S_IDLE;
          else                 w_cpu_en = 1'b1;
        end
        S_STEP: begin
          w_next   = S_IDLE;
          w_cpu_en = !i_halt_req;
        end
        S_LOAD: begin
          if (i_halt_req) begin
            w_next = S_IDLE;
          end else begin
            w_ld_ready = 1'b1;
            if (io_bus.ld_valid) begin
              w_wr = 1'b1;
              if (r_ptr == 4'hF) w_next = S_IDLE;
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 4'h0;
      r_load_done <= 1'b0;
      r_cycle_cnt <= 8'h00;
    end else begin
      r_state     <= w_next;
      r_load_done <= w_wr && (r_ptr == 4'hF);
      if (w_enter_load)  r_ptr <= 4'h0;
      else if (w_wr)     r_ptr <= r_ptr + 4'h1;  // wraps to 0 after address 15
      if (w_enter_load)
        r_cycle_cnt <= 8'h00;
      else if (w_cpu_en && (r_cycle_cnt != 8'hFF))
        r_cycle_cnt <= r_cycle_cnt + 8'h01;
    end
  end

  assign io_bus.ld_ready  = w_ld_ready;
  assign io_bus.mem_we    = w_wr;
  assign io_bus.mem_waddr = r_ptr;
  assign io_bus.mem_wdata = io_bus.ld_data;
  assign o_cpu_en         = w_cpu_en;
  assign o_state          = r_state;
  assign o_halted         = (r_state == S_IDLE);
  assign o_load_done      = r_load_done;
  assign o_bp_hit         = w_bp_hit;
  assign o_cycle_cnt      = r_cycle_cnt;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl: memory writes checked against a scoreboard queue filled when bytes are offered.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Breakpoint expectations follow TD4_BREAKPOINT_EN as seen by this compile.
module tb_td4_run_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       run_req, halt_req, step_req, load_req;
  logic [3:0] pc, bp_addr;
  logic       bp_en;
  logic       cpu_en, halted, load_done, bp_hit;
  logic [1:0] state;
  logic [7:0] cycle_cnt;

  td4_run_ctrl_if bus ();

  td4_run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_run_req   (run_req),
    .i_halt_req  (halt_req),
    .i_step_req  (step_req),
    .i_load_req  (load_req),
    .i_pc        (pc),
    .i_bp_addr   (bp_addr),
    .i_bp_en     (bp_en),
    .io_bus      (bus),
    .o_cpu_en    (cpu_en),
    .o_state     (state),
    .o_halted    (halted),
    .o_load_done (load_done),
    .o_bp_hit    (bp_hit),
    .o_cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_writes = 0;
  int n_done   = 0;
  int n_cpu    = 0;
  logic [11:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Falling-edge sample: pop the scoreboard on every memory write.
  task automatic look();
    logic [11:0] e;
    #4;
    if (bus.mem_we === 1'b1) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_we", {31'd0, bus.mem_we}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("mem_waddr", {28'd0, bus.mem_waddr}, {28'd0, e[11:8]});
        check("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, e[7:0]});
      end
    end
    if (load_done === 1'b1) n_done++;
    if (cpu_en === 1'b1) n_cpu++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    look();
    adv();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"},     {30'd0, state}, 32'd0);
    check({tag, "_halted"},    {31'd0, halted}, 32'd1);
    check({tag, "_cpu_en"},    {31'd0, cpu_en}, 32'd0);
    check({tag, "_ld_ready"},  {31'd0, bus.ld_ready}, 32'd0);
    check({tag, "_mem_we"},    {31'd0, bus.mem_we}, 32'd0);
    check({tag, "_mem_waddr"}, {28'd0, bus.mem_waddr}, 32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_bp_hit"},    {31'd0, bp_hit}, 32'd0);
    check({tag, "_cycle_cnt"}, {24'd0, cycle_cnt}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, c0, k;
    rst = 1'b1; run_req = 0; halt_req = 0; step_req = 0; load_req = 0;
    pc = 0; bp_addr = 0; bp_en = 0;
    bus.ld_valid = 0; bus.ld_data = 0;
    adv();
    cycle();
    rst = 1'b0;
    look();
    check_reset_vals("reset");
    adv();

    // Full 16-byte load with ld_valid held.
    w0 = n_writes; d0 = n_done;
    load_req = 1; look();
    check("idle_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    adv();
    load_req = 0;
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = 1; bus.ld_data = i[7:0];
      sb_q.push_back({i[3:0], i[7:0]});
      look();
      check("load_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
      adv();
    end
    bus.ld_valid = 0;
    look();
    check("full_load_state", {30'd0, state}, 32'd0);
    check("full_load_done", {31'd0, load_done}, 32'd1);
    adv();
    look();
    check("full_load_done_pulse", {31'd0, load_done}, 32'd0);
    check("full_load_writes", n_writes - w0, 32'd16);
    check("full_load_done_cnt", n_done - d0, 32'd1);
    adv();

    // Partial load with gaps, then halt abort; next load restarts at 0.
    w0 = n_writes; d0 = n_done; k = 0;
    load_req = 1; cycle(); load_req = 0;
    for (int i = 0; i < 9; i++) begin
      bus.ld_valid = (i % 2 == 0);
      bus.ld_data  = 8'hA0 + i[7:0];
      if (bus.ld_valid) begin
        sb_q.push_back({k[3:0], bus.ld_data});
        k++;
      end
      cycle();
    end
    halt_req = 1; bus.ld_valid = 1; bus.ld_data = 8'hEE;
    look();
    check("abort_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    check("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
    adv();
    halt_req = 0; bus.ld_valid = 0;
    look();
    check("abort_state", {30'd0, state}, 32'd0);
    check("abort_writes", n_writes - w0, 32'd5);
    check("abort_no_done", n_done - d0, 32'd0);
    adv();
    load_req = 1; cycle(); load_req = 0;
    bus.ld_valid = 1; bus.ld_data = 8'h5A;
    sb_q.push_back({4'h0, 8'h5A});
    cycle();
    bus.ld_valid = 0; halt_req = 1; cycle(); halt_req = 0;
    look();
    check("reload_state", {30'd0, state}, 32'd0);
    check("reload_cnt_clear", {24'd0, cycle_cnt}, 32'd0);
    adv();

    // Single step.
    c0 = n_cpu;
    step_req = 1; look();
    check("step_req_cycle_cpu_en", {31'd0, cpu_en}, 32'd0);
    adv();
    step_req = 0; look();
    check("step_state", {30'd0, state}, 32'd2);
    check("step_cpu_en", {31'd0, cpu_en}, 32'd1);
    adv();
    look();
    check("step_back_idle", {30'd0, state}, 32'd0);
    check("step_cycle_cnt", {24'd0, cycle_cnt}, 32'd1);
    check("step_cpu_en_once", n_cpu - c0, 32'd1);
    adv();
    // Halt during the STEP cycle suppresses execution.
    step_req = 1; cycle(); step_req = 0;
    halt_req = 1; look();
    check("step_halt_cpu_en", {31'd0, cpu_en}, 32'd0);
    adv();
    halt_req = 0; look();
    check("step_halt_state", {30'd0, state}, 32'd0);
    check("step_halt_cnt", {24'd0, cycle_cnt}, 32'd1);
    adv();

    // Breakpoint at pc=3.
    bp_en = 1; bp_addr = 4'd3; pc = 0;
    run_req = 1; cycle(); run_req = 0;
    look();
    check("run_state", {30'd0, state}, 32'd1);
    check("run_pc0_cpu_en", {31'd0, cpu_en}, 32'd1);
    adv();
    for (int p = 1; p < 3; p++) begin
      pc = p[3:0]; look();
      check("run_pc_cpu_en", {31'd0, cpu_en}, 32'd1);
      adv();
    end
    pc = 4'd3; look();
`ifdef TD4_BREAKPOINT_EN
    check("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("bp_hit", {31'd0, bp_hit}, 32'd1);
    adv();
    look();
    check("bp_state_idle", {30'd0, state}, 32'd0);
    check("bp_hit_pulse", {31'd0, bp_hit}, 32'd0);
    adv();
    run_req = 1; cycle(); run_req = 0;
    look();
    check("resume_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("resume_no_bp_hit", {31'd0, bp_hit}, 32'd0);
    adv();
`else
    check("nobp_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("nobp_bp_hit", {31'd0, bp_hit}, 32'd0);
    adv();
    look();
    check("nobp_state_run", {30'd0, state}, 32'd1);
    adv();
`endif
    pc = 4'd4;
    halt_req = 1; look();
    check("run_halt_cpu_en", {31'd0, cpu_en}, 32'd0);
    adv();
    halt_req = 0; look();
    check("run_halt_state", {30'd0, state}, 32'd0);
    adv();

    // run+halt together stays idle; long run saturates the counter.
    run_req = 1; halt_req = 1; look();
    check("run_halt_same_cpu_en", {31'd0, cpu_en}, 32'd0);
    adv();
    run_req = 0; halt_req = 0; look();
    check("run_halt_same_state", {30'd0, state}, 32'd0);
    adv();
    bp_en = 0;
    run_req = 1; cycle(); run_req = 0;
    for (int i = 0; i < 300; i++) cycle();
    // Reset mid-RUN.
    rst = 1; look();
    check("sat_cycle_cnt", {24'd0, cycle_cnt}, 32'd255);
    check("sat_state_run", {30'd0, state}, 32'd1);
    check("rst_run_cpu_en", {31'd0, cpu_en}, 32'd0);
    adv();
    rst = 0; look();
    check_reset_vals("rst_run");
    adv();

    // Reset mid-LOAD.
    d0 = n_done;
    load_req = 1; cycle(); load_req = 0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1; bus.ld_data = 8'hC0 + i[7:0];
      sb_q.push_back({i[3:0], bus.ld_data});
      cycle();
    end
    rst = 1; look();
    check("rst_load_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_load_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    adv();
    rst = 0; bus.ld_valid = 0; look();
    check_reset_vals("rst_load");
    check("rst_load_no_done", n_done - d0, 32'd0);
    adv();
    cycle();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
